seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//  Multi-cycle restoring divider for the MIPS DIV/DIVU path; one quotient bit per clock.
//  Consumes a WIDTH-bit subtractor built from the team's carry-select adders:
//  B inverted, Cin=1, carry-out = no-borrow.
//  Produces quotient/remainder for the HI/LO write-back stage via a start/busy/done handshake.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width in bits (even, >=4)
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high reset
//  start         in   1      request; accepted only when busy==0
//  is_signed     in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
//  dividend      in   WIDTH  sampled on accepted start
//  divisor       in   WIDTH  sampled on accepted start
//  busy          out  1      high from cycle after accept until done cycle inclusive
//  done          out  1      one-cycle pulse; quotient/remainder valid from this cycle
//  quotient      out  WIDTH  result -> LO; held until next accepted start
//  remainder     out  WIDTH  result -> HI; held until next accepted start
//  div_by_zero   out  1      set with done when divisor==0; held like results
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, div_by_zero = 0; quotient = remainder = 0.
//    Reset mid-operation aborts immediately; no done is produced.
//  States: IDLE -> (start) -> RUN -> (count==0) -> FIX -> DONE -> IDLE.
//    Zero divisor: IDLE -> DONE directly.
//  Accept (IDLE & start): latch |dividend|, |divisor|, q_neg, r_neg; rem=0; count=WIDTH.
//    Absolute value applies only when is_signed. q_neg = sign(dvd) XOR sign(dvs).
//    r_neg = sign(dvd).
//  RUN, each cycle:
//    {rem,quo} <<= 1; trial = rem - dvs (WIDTH+1 bits).
//    No borrow: rem=trial, quo[0]=1. Borrow: rem restored, quo[0]=0.
//    count decrements.
//  FIX: quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem (WIDTH-bit wrap).
//  DONE: done=1 for exactly one cycle; busy=1 in same cycle; next cycle busy=0.
//  Latency: start accepted at edge N -> done high in cycle N+WIDTH+2 (34 for WIDTH=32).
//  Divisor==0: done at cycle N+1; quotient = all ones; remainder = dividend (raw);
//    div_by_zero=1.
//  Signed overflow (min / -1): quotient = min (0x80000000), remainder = 0, no flag.
//    Falls out of the unsigned core plus wrap negation.
//  start while busy: ignored; no queueing.
//  start in the DONE cycle: ignored. Back-to-back starts need one IDLE cycle.
//  div_by_zero clears on next accepted start. Results are never modified outside FIX/DONE.
// STRUCTURE
//  Shared package divider_pkg holds:
//    state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3);
//    DIV_WIDTH default = 32;
//    count width = clog2(WIDTH+1).
//  Sub-module divider_sub_stage (trial subtract + restore mux):
//    chains WIDTH/2 CarrySelectAdder_2bit instances;
//    one extra bit for the shifted-out remainder MSB.
//  Top module holds FSM, counter, operand/sign registers and the sign-fix negators.
// TESTING
//  DIVU 100 / 7, start at cycle 0
//    -> done only at cycle 34; quotient=14, remainder=2, busy high cycles 1..34.
//  DIV -7 / 2
//    -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1), div_by_zero=0.
//  DIVU 0x12345678 / 0
//    -> done at cycle 1; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
//  DIV 0x80000000 / 0xFFFFFFFF
//    -> quotient=0x80000000, remainder=0; DIVU 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, rem=0.
//  reset pulsed at cycle 10 of a run
//    -> busy=0, outputs=0 next cycle, no done; new start 5 / 5 -> q=1, r=0.
//  start re-pulsed during RUN with other operands
//    -> ignored; original result delivered, done pulses exactly once.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and sizing for the restoring divider
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = count_width(DIV_WIDTH);

endpackage

// File: rtl/carry_select_adder_2bit.sv
// rtl/carry_select_adder_2bit.sv - 2-bit carry-select adder slice
module CarrySelectAdder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic [2:0] res_c0;
  logic [2:0] res_c1;

  // Both carry-in outcomes are precomputed; the incoming carry only drives the mux.
  assign res_c0 = {1'b0, a} + {1'b0, b};
  assign res_c1 = {1'b0, a} + {1'b0, b} + 3'd1;
  assign sum    = cin ? res_c1[1:0] : res_c0[1:0];
  assign cout   = cin ? res_c1[2]   : res_c0[2];

endmodule

// File: rtl/divider_sub_stage.sv
// rtl/divider_sub_stage.sv - one restoring step: shift, trial subtract, restore mux
module divider_sub_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0]   shifted;
  logic               shifted_msb;
  logic [WIDTH-1:0]   dvs_n;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH/2:0]   carry;

  assign shifted     = {rem[WIDTH-2:0], shift_in};
  assign shifted_msb = rem[WIDTH-1];
  assign dvs_n       = ~dvs;
  assign carry[0]    = 1'b1;

  // Subtraction as shifted + ~dvs + 1; final carry-out means no borrow.
  for (genvar g = 0; g < WIDTH/2; g++) begin : g_csa
    CarrySelectAdder_2bit u_csa (
      .a    (shifted[2*g+1:2*g]),
      .b    (dvs_n[2*g+1:2*g]),
      .cin  (carry[g]),
      .sum  (diff[2*g+1:2*g]),
      .cout (carry[g+1])
    );
  end

  // Extra top bit: its subtrahend bit is 0 (inverted to 1), so no-borrow is msb | carry.
  assign q_bit    = shifted_msb | carry[WIDTH/2];
  assign rem_next = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle signed/unsigned restoring divider
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    count_q;
  logic             q_neg, r_neg;
  logic             accept, dvs_zero;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  assign dvs_zero = (divisor == '0);
  assign abs_dvd  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_dvs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  divider_sub_stage #(.WIDTH(WIDTH)) u_stage (
    .rem      (rem_q),
    .shift_in (quo_q[WIDTH-1]),
    .dvs      (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    case (state)
      ST_IDLE: if (start) begin
        accept     = 1'b1;
        state_next = dvs_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN:  if (count_q == CW'(1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latch, one quotient bit per RUN cycle, and sign fix-up into the result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      count_q     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          rem_q       <= '0;
          quo_q       <= abs_dvd;
          dvs_q       <= abs_dvs;
          count_q     <= CW'(WIDTH);
          q_neg       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg       <= is_signed & dividend[WIDTH-1];
          div_by_zero <= dvs_zero;
          if (dvs_zero) begin
            quotient  <= '1;
            remainder <= dividend;
          end
        end
        ST_RUN: begin
          rem_q   <= rem_next;
          quo_q   <= {quo_q[WIDTH-2:0], q_bit};
          count_q <= count_q - CW'(1);
        end
        ST_FIX: begin
          quotient  <= q_neg ? -quo_q : quo_q;
          remainder <= r_neg ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule
